fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Instruction-fetch front end that sits directly upstream of the IF/ID register.
//  Issues PC-sequential requests to instruction memory over a valid/ready request
//  channel and accepts in-order responses. Buffers up to DEPTH fetched {PC, instr}
//  pairs and presents the oldest one to Decode.
//  Honours the hazard-unit stall (stallD) and redirects on taken branches or PC
//  writes from Execute/Writeback.
// PARAMETERS
//  DEPTH     4          buffer entries and max outstanding requests (power of 2, >=2)
//  RESET_PC  32'h0      first fetch address after reset
// PORTS
//  clk             in   1   sole clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   request address valid
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_rsp_valid  in   1   response data valid (no backpressure; always accepted)
//  imem_rsp_data   in   32  instruction word, returned in request order, >=1 cycle latency
//  redirect        in   1   flush and restart fetch (BranchTakenE | PCSrcW)
//  redirect_pc     in   32  new fetch address, sampled when redirect=1
//  stallD          in   1   Decode not consuming this cycle
//  instr_valid_d   out  1   instr_d/pc_d hold a valid entry
//  instr_d         out  32  oldest buffered instruction
//  pc_d            out  32  PC of instr_d
// BEHAVIOUR
//  - Reset (reset=0, async): queue empty, outstanding=0, drop_cnt=0, fetch_pc=RESET_PC,
//    rsp_pc=RESET_PC. Outputs: imem_req_valid=0, instr_valid_d=0, instr_d=0, pc_d=0.
//  - Issue condition: !redirect && (count+outstanding < DEPTH), evaluated on registered
//    counts. When met, imem_req_valid=1 and imem_req_addr=fetch_pc.
//  - Request transfer: occurs when valid&&ready. On transfer, fetch_pc+=4 (mod 2^32) and
//    outstanding++. Addr is held stable while valid&&!ready; only redirect may withdraw valid.
//  - Response, drop_cnt=0: {rsp_pc, rsp_data} is pushed to the queue; rsp_pc+=4.
//  - Response, drop_cnt>0: response is discarded; drop_cnt--.
//  - Every response decrements outstanding. Credit check guarantees the queue never overflows.
//  - Latency: a response accepted in cycle N is visible on instr_d in cycle N+1 when the queue
//    was empty. There is no combinational bypass.
//  - Pop: when instr_valid_d && !stallD, head advances. Outputs read the head combinationally
//    from registered storage. push+pop in one cycle leaves count unchanged (valid when full).
//  - Redirect has top priority, even while stallD=1:
//    - Queue cleared; fetch_pc and rsp_pc are loaded from redirect_pc.
//    - drop_cnt = outstanding (+1 if a request transfers this cycle, -1 if a response
//      arrives this cycle).
//    - No request is issued in the redirect cycle; the next cycle fetches redirect_pc.
//  - State fetch_state_t:
//    - RUN (drop_cnt=0): redirect with nonzero drop count -> DRAIN.
//    - DRAIN (drop_cnt>0): issue continues normally; -> RUN when the last stale response
//      is dropped.
//    - Redirect in DRAIN re-adds the new in-flight count to drop_cnt.
//  - Counters: count, outstanding and drop_cnt are $clog2(DEPTH+1) bits wide; none exceeds
//    DEPTH. Queue pointers wrap modulo DEPTH.
//  - Reset asserted mid-operation: all state returns to reset values immediately. Responses
//    after release that belong to pre-reset requests are the memory's responsibility (the
//    memory is reset together with this block).
// STRUCTURE
//  - cpu_pkg: XLEN=32, INSTR_W=32, PC_STEP=4, typedef enum logic {RUN, DRAIN} fetch_state_t.
//  - Sub-module fetch_fifo #(DEPTH, W=64): circular buffer with push, pop and synchronous
//    clear; outputs head, count, full and empty. Storage is not reset (head data is
//    qualified by instr_valid_d; instr_d/pc_d are forced to 0 when empty).
//  - Top level holds fetch_pc, rsp_pc, outstanding, drop_cnt, the state register and the
//    issue logic.
// TESTING
//  1. Reset release, ready=1, 1-cycle memory, stallD=0
//     -> requests at 0x0,0x4,0x8...; first instr_valid_d 2 cycles after first request;
//        pc_d increments by 4 every cycle.
//  2. stallD=1 held for 10 cycles
//     -> exactly DEPTH=4 requests issued, then imem_req_valid=0; instr_d/pc_d stable;
//        release -> pop order 0x0,0x4,0x8,0xC, then fetch resumes at 0x10.
//  3. 3-cycle memory latency, 3 requests outstanding, redirect to 0x100
//     -> 3 stale responses dropped, queue empty; first new request 0x100; pc_d=0x100 next.
//  4. Redirect to 0x200 while stallD=1 and queue full
//     -> instr_valid_d=0 next cycle; subsequent output sequence 0x200,0x204.
//  5. imem_req_ready=0 for 5 cycles with valid=1
//     -> imem_req_addr constant; fetch_pc advances only on handshake.
//  6. Assert reset mid-DRAIN
//     -> all outputs 0 asynchronously; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared widths, the PC increment and the fetch state type used by the
//   instruction-fetch front end.
//   Contents:
//     XLEN, INSTR_W  - address and instruction word widths
//     PC_STEP        - byte distance between sequential instruction words
//     fetch_state_t  - RUN: no stale responses pending
//                      DRAIN: responses from before a redirect still in flight
//     next_pc()      - sequential successor of a PC (wraps modulo 2^XLEN)
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Circular buffer holding fetched {pc, instr} pairs in arrival order.
//   The head entry is read combinationally from registered storage, so data
//   written in cycle N is visible at the head in cycle N+1 at the earliest.
//   Storage is not reset; callers qualify head with empty.
// Ports:
//   clk        in   1              rising-edge clock
//   reset      in   1              asynchronous active-low reset of pointers/count
//   clear      in   1              synchronous flush, wins over push and pop
//   push       in   1              write push_data at the tail
//   push_data  in   W              entry to write
//   pop        in   1              advance the head (ignored when empty)
//   head       out  W              oldest entry
//   count      out  clog2(DEPTH+1) number of valid entries
//   full       out  1              count == DEPTH
//   empty      out  1              count == 0
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,               // power of 2, >= 2
  parameter int W     = XLEN + INSTR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction-fetch front end feeding the IF/ID register. Issues sequential
//   fetch requests, accepts in-order responses, buffers up to DEPTH {pc, instr}
//   pairs and presents the oldest to Decode. A redirect flushes the buffer,
//   restarts fetch at redirect_pc and discards responses still in flight.
// Ports:
//   clk             in   1   rising-edge clock
//   reset           in   1   asynchronous active-low reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_addr   out  32  fetch address
//   imem_req_ready  in   1   memory accepts the request this cycle
//   imem_rsp_valid  in   1   response valid (always accepted)
//   imem_rsp_data   in   32  instruction word, returned in request order
//   redirect        in   1   flush and restart fetch
//   redirect_pc     in   32  restart address
//   stallD          in   1   Decode does not consume this cycle
//   instr_valid_d   out  1   instr_d/pc_d hold a valid entry
//   instr_d         out  32  oldest buffered instruction (0 when empty)
//   pc_d            out  32  PC of instr_d (0 when empty)
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,      // power of 2, >= 2
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               stallD,
  output logic               instr_valid_d,
  output logic [INSTR_W-1:0] instr_d,
  output logic [XLEN-1:0]    pc_d
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = XLEN + INSTR_W;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  fetch_state_t    state_reg;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] rsp_pc_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_cnt_reg;
  logic [CW-1:0]   drop_cnt_next;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FW-1:0]   fifo_head;
  logic            fifo_push;
  logic            fifo_pop;

  logic [CW:0]     credit_used;
  logic            issue;
  logic            req_fire;
  logic            rsp_keep;

  // Every issued request owns a buffer slot until it is popped or dropped, so
  // the buffer can never overflow regardless of response timing.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign issue       = !redirect && (credit_used < CREDIT_MAX);

  // Gating with reset keeps the request channel quiet while reset is held,
  // including the asynchronous part before the next clock edge.
  assign imem_req_valid = reset && issue;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are kept only when no stale responses remain to be dropped.
  assign rsp_keep  = imem_rsp_valid && (state_reg == RUN);
  assign fifo_push = rsp_keep && (!fifo_full || fifo_pop);
  assign fifo_pop  = !fifo_empty && !stallD;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_fire && !imem_rsp_valid) begin
      outstanding_next = outstanding_reg + 1'b1;
    end else if (!req_fire && imem_rsp_valid) begin
      outstanding_next = outstanding_reg - 1'b1;
    end
  end

  // On a redirect every request still in flight after this cycle is stale.
  // outstanding already counts the ones being dropped in DRAIN, so the new
  // drop count is simply the post-update outstanding value.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    state_next    = state_reg;
    if (redirect) begin
      drop_cnt_next = outstanding_next;
      state_next    = (outstanding_next != '0) ? DRAIN : RUN;
    end else if (imem_rsp_valid && (state_reg == DRAIN)) begin
      drop_cnt_next = drop_cnt_reg - 1'b1;
      if (drop_cnt_reg == CW'(1)) state_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      if (redirect) begin
        fetch_pc_reg <= redirect_pc;
        rsp_pc_reg   <= redirect_pc;
      end else begin
        if (req_fire)  fetch_pc_reg <= next_pc(fetch_pc_reg);
        if (fifo_push) rsp_pc_reg   <= next_pc(rsp_pc_reg);
      end
    end
  end

  // Redirect drives the synchronous clear, which overrides push and pop.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (fifo_push),
    .push_data ({rsp_pc_reg, imem_rsp_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid_d = !fifo_empty;
  assign instr_d       = fifo_empty ? '0 : fifo_head[INSTR_W-1:0];
  assign pc_d          = fifo_empty ? '0 : fifo_head[FW-1:INSTR_W];

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
//   Scoreboard bench for fetch_buffer. A memory model answers requests after a
//   configurable latency; each accepted request pushes its expected {pc, instr}
//   onto a queue that is compared whenever Decode consumes an entry.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stallD;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;

  always #5 clk = ~clk;

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stallD         (stallD),
    .instr_valid_d  (instr_valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_ent;
  mreq_t       m_ent;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] hold_addr;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int          hs_total = 0;
  int          hs_base = 0;
  int          pop_total = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed=%08h expected=%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: one in-order response per cycle once the head request is due.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor/scoreboard, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        model_pc = RESET_PC;
      end else if (redirect) begin
        expect_eq("no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
        exp_q.delete();
        model_pc = redirect_pc;
      end else begin
        if (instr_valid_d && !stallD) begin
          if (exp_q.size() == 0) begin
            expect_eq("pop_unexpected", {31'b0, instr_valid_d}, 32'd0);
          end else begin
            exp_ent = exp_q.pop_front();
            expect_eq("pop_pc", pc_d, exp_ent[63:32]);
            expect_eq("pop_instr", instr_d, exp_ent[31:0]);
            pop_total++;
            $display("pop  pc=%08h instr=%08h t=%0t", pc_d, instr_d, $time);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          expect_eq("req_addr", imem_req_addr, model_pc);
          m_ent.due  = cyc + lat;
          m_ent.addr = imem_req_addr;
          mem_q.push_back(m_ent);
          exp_q.push_back({model_pc, mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
          hs_total++;
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    stallD         = 1'b0;
    #2 reset = 1'b0;
    #1;
    expect_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    expect_eq("rst_instr_valid", {31'b0, instr_valid_d}, 32'd0);
    expect_eq("rst_instr_d", instr_d, 32'd0);
    expect_eq("rst_pc_d", pc_d, 32'd0);
    repeat (2) tick();

    // 1: streaming with a 1-cycle memory.
    reset = 1'b1;
    @(negedge clk);
    expect_eq("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    expect_eq("t1_first_req_addr", imem_req_addr, RESET_PC);
    tick(); @(negedge clk);
    expect_eq("t1_no_bypass", {31'b0, instr_valid_d}, 32'd0);
    tick(); @(negedge clk);
    expect_eq("t1_first_valid", {31'b0, instr_valid_d}, 32'd1);
    expect_eq("t1_first_pc", pc_d, RESET_PC);
    for (int i = 0; i < 6; i++) begin
      tick(); @(negedge clk);
      expect_eq("t1_stream", {31'b0, instr_valid_d}, 32'd1);
    end

    // 2: Decode stalled from reset release; credits cap requests at DEPTH.
    tick();
    reset  = 1'b0;
    stallD = 1'b1;
    tick(); tick();
    reset   = 1'b1;
    hs_base = hs_total;
    for (int i = 0; i < 10; i++) begin
      tick(); @(negedge clk);
      if (i >= 1) begin
        expect_eq("t2_pc_hold", pc_d, RESET_PC);
        expect_eq("t2_instr_hold", instr_d, mem_word(RESET_PC));
      end
    end
    expect_eq("t2_req_count", 32'(hs_total - hs_base), 32'(DEPTH));
    expect_eq("t2_req_stopped", {31'b0, imem_req_valid}, 32'd0);
    tick();
    stallD = 1'b0;
    repeat (12) tick();

    // 3: redirect with stale responses in flight behind a 3-cycle memory.
    lat = 3;
    repeat (8) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    expect_eq("t3_flushed", {31'b0, instr_valid_d}, 32'd0);
    expect_eq("t3_new_req_valid", {31'b0, imem_req_valid}, 32'd1);
    expect_eq("t3_new_req_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      expect_eq("t3_stale_dropped", {31'b0, instr_valid_d}, 32'd0);
    end
    tick(); @(negedge clk);
    expect_eq("t3_first_valid", {31'b0, instr_valid_d}, 32'd1);
    expect_eq("t3_first_pc", pc_d, 32'h100);
    repeat (6) tick();
    lat = 1;
    repeat (6) tick();

    // 4: redirect while stalled with a full buffer.
    stallD = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    expect_eq("t4_full_valid", {31'b0, instr_valid_d}, 32'd1);
    expect_eq("t4_full_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    stallD   = 1'b0;
    @(negedge clk);
    expect_eq("t4_flushed", {31'b0, instr_valid_d}, 32'd0);
    expect_eq("t4_pc_zero", pc_d, 32'd0);
    expect_eq("t4_instr_zero", instr_d, 32'd0);
    tick(); tick(); @(negedge clk);
    expect_eq("t4_first_pc", pc_d, 32'h200);
    tick(); @(negedge clk);
    expect_eq("t4_second_pc", pc_d, 32'h204);
    repeat (4) tick();

    // 5: memory not ready; the request must hold its address.
    imem_req_ready = 1'b0;
    hold_addr      = model_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_eq("t5_valid_held", {31'b0, imem_req_valid}, 32'd1);
      expect_eq("t5_addr_held", imem_req_addr, hold_addr);
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (8) tick();

    // 6: reset asserted mid-DRAIN, then restart.
    lat = 3;
    repeat (6) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    #1;
    expect_eq("t6_drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    reset = 1'b0;
    #1;
    expect_eq("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    expect_eq("t6_async_instr_valid", {31'b0, instr_valid_d}, 32'd0);
    expect_eq("t6_async_instr_d", instr_d, 32'd0);
    expect_eq("t6_async_pc_d", pc_d, 32'd0);
    tick(); tick();
    reset = 1'b1;
    lat   = 1;
    @(negedge clk);
    expect_eq("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    expect_eq("t6_restart_addr", imem_req_addr, RESET_PC);
    repeat (10) tick();
    @(negedge clk);
    expect_eq("sb_pops_seen", 32'(pop_total > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
